axi_master_bridge: RTL

- AXI4 initiator that turns a simple core-side request interface (cache/CPU port) into AXI AR/R and AW/W/B transactions.
- Sits between a core memory port and one master port of the AXI interconnect. Slaves on the far side include the DRAM wrapper and SRAM wrappers.
- Handles one transaction at a time. Bursts are INCR, 32-bit beats, 1 to 16 beats.

---
 rtl/axi_mst_pkg.sv | 24 ++
 rtl/axi_mst_beat_cnt.sv | 33 +++
 rtl/axi_master_bridge.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mst_pkg.sv
// Shared types and constants for the AXI master bridge and its beat counter.
package axi_mst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RADDR,
        ST_RDATA,
        ST_WADDR,
        ST_WDATA,
        ST_WRESP,
        ST_DONE
    } mst_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
        logic        write;
    } mst_req_t;

    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_mst_beat_cnt.sv
// 4-bit burst beat counter; last flags the beat whose index equals len.
module axi_mst_beat_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    input  logic [3:0] len,
    output logic       last
);

    logic [3:0] cnt_q, cnt_d;

    assign last = (cnt_q == len);

    // Holding at len on the final beat keeps a len=15 burst from wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !last) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axi_master_bridge.sv
// Core-port to AXI4 initiator bridge, one INCR transaction at a time.
// Define AXI_MST_PERF_EN to add the perf_rd_cnt/perf_wr_cnt/perf_stall_cnt outputs.
module axi_master_bridge
    import axi_mst_pkg::*;
#(
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] MST_ID = '0
) (
    input  logic            ACLK,
    input  logic            ARESETn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [31:0]     req_addr,
    input  logic [3:0]      req_len,
    input  logic            wd_valid,
    input  logic [31:0]     wd_data,
    input  logic [3:0]      wd_strb,
    output logic            wd_ready,
    output logic            rd_valid,
    output logic [31:0]     rd_data,
    output logic            rd_last,
    output logic            done,
    output logic            err,
    output logic [ID_W-1:0] ARID,
    output logic [31:0]     ARADDR,
    output logic [7:0]      ARLEN,
    output logic [2:0]      ARSIZE,
    output logic [1:0]      ARBURST,
    output logic            ARVALID,
    input  logic            ARREADY,
    input  logic [ID_W-1:0] RID,
    input  logic [31:0]     RDATA,
    input  logic [1:0]      RRESP,
    input  logic            RLAST,
    input  logic            RVALID,
    output logic            RREADY,
    output logic [ID_W-1:0] AWID,
    output logic [31:0]     AWADDR,
    output logic [7:0]      AWLEN,
    output logic [2:0]      AWSIZE,
    output logic [1:0]      AWBURST,
    output logic            AWVALID,
    input  logic            AWREADY,
    output logic [31:0]     WDATA,
    output logic [3:0]      WSTRB,
    output logic            WLAST,
    output logic            WVALID,
    input  logic            WREADY,
    input  logic [ID_W-1:0] BID,
    input  logic [1:0]      BRESP,
    input  logic            BVALID,
    output logic            BREADY
`ifdef AXI_MST_PERF_EN
    ,
    output logic [31:0]     perf_rd_cnt,
    output logic [31:0]     perf_wr_cnt,
    output logic [31:0]     perf_stall_cnt
`endif
);

    mst_state_e state_q, state_d;
    mst_req_t   req_q, req_d;
    logic       err_q, err_d;
    logic       out_en_q, out_en_d;
    logic       cnt_clr, cnt_inc, beat_last;

    logic unused_ids;
    assign unused_ids = ^{RID, BID};

    axi_mst_beat_cnt u_beat_cnt (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .len   (req_q.len),
        .last  (beat_last)
    );

    // out_en_q keeps req_ready low while reset is held, so every output is 0 then.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        err_d     = err_q;
        out_en_d  = 1'b1;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        req_ready = 1'b0;
        wd_ready  = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        rd_last   = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        ARID      = '0;
        ARADDR    = '0;
        ARLEN     = '0;
        ARSIZE    = '0;
        ARBURST   = '0;
        ARVALID   = 1'b0;
        RREADY    = 1'b0;
        AWID      = '0;
        AWADDR    = '0;
        AWLEN     = '0;
        AWSIZE    = '0;
        AWBURST   = '0;
        AWVALID   = 1'b0;
        WDATA     = '0;
        WSTRB     = '0;
        WLAST     = 1'b0;
        WVALID    = 1'b0;
        BREADY    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = out_en_q;
                if (req_valid && out_en_q) begin
                    req_d   = '{addr: req_addr, len: req_len, write: req_write};
                    state_d = req_write ? ST_WADDR : ST_RADDR;
                end
            end
            ST_RADDR: begin
                ARVALID = 1'b1;
                ARADDR  = req_q.addr;
                ARLEN   = {4'd0, req_q.len};
                ARSIZE  = SIZE_WORD;
                ARBURST = BURST_INCR;
                ARID    = MST_ID;
                if (ARREADY) state_d = ST_RDATA;
            end
            ST_RDATA: begin
                RREADY   = 1'b1;
                rd_valid = RVALID;
                rd_data  = RDATA;
                rd_last  = RLAST;
                if (RVALID) begin
                    cnt_inc = 1'b1;
                    if ((RRESP != RESP_OKAY) || (RLAST != beat_last)) err_d = 1'b1;
                    if (beat_last) state_d = ST_DONE;
                end
            end
            ST_WADDR: begin
                AWVALID = 1'b1;
                AWADDR  = req_q.addr;
                AWLEN   = {4'd0, req_q.len};
                AWSIZE  = SIZE_WORD;
                AWBURST = BURST_INCR;
                AWID    = MST_ID;
                if (AWREADY) state_d = ST_WDATA;
            end
            ST_WDATA: begin
                WVALID   = wd_valid;
                WDATA    = wd_data;
                WSTRB    = wd_strb;
                WLAST    = beat_last;
                wd_ready = WREADY;
                if (wd_valid && WREADY) begin
                    cnt_inc = 1'b1;
                    if (beat_last) state_d = ST_WRESP;
                end
            end
            ST_WRESP: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    if (BRESP != RESP_OKAY) err_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                err     = err_q;
                err_d   = 1'b0;
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            err_q    <= 1'b0;
            out_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            err_q    <= err_d;
            out_en_q <= out_en_d;
        end
    end

`ifdef AXI_MST_PERF_EN
    logic [31:0] perf_rd_q, perf_rd_d;
    logic [31:0] perf_wr_q, perf_wr_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic        stall;

    always_comb begin
        perf_rd_d    = perf_rd_q;
        perf_wr_d    = perf_wr_q;
        perf_stall_d = perf_stall_q;
        stall = (ARVALID && !ARREADY) || (AWVALID && !AWREADY) || (WVALID && !WREADY) ||
                (RREADY && !RVALID) || (BREADY && !BVALID);
        if (state_q == ST_DONE) begin
            if (!req_q.write && (perf_rd_q != '1)) perf_rd_d = perf_rd_q + 32'd1;
            if (req_q.write && (perf_wr_q != '1))  perf_wr_d = perf_wr_q + 32'd1;
        end
        if (stall && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            perf_rd_q    <= '0;
            perf_wr_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_rd_q    <= perf_rd_d;
            perf_wr_q    <= perf_wr_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_rd_cnt    = perf_rd_q;
    assign perf_wr_cnt    = perf_wr_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
